// File: rtl/act_pkg.sv
// Shared definitions for the multi-lane activation unit: mode encodings,
// the mode type and default datapath dimensions.
package act_pkg;

    localparam logic [1:0] ACT_BYPASS = 2'd0;
    localparam logic [1:0] ACT_RELU   = 2'd1;
    localparam logic [1:0] ACT_LEAKY  = 2'd2;
    localparam logic [1:0] ACT_CLIP   = 2'd3;

    typedef logic [1:0] act_mode_t;

    localparam int ACT_DATA_W     = 32;
    localparam int ACT_LANES      = 4;
    localparam int ACT_LEAK_SHIFT = 3;

endpackage

// File: rtl/act_lane.sv
// Combinational per-lane activation. The sign bit and the leaky term
// (x >>> LEAK_SHIFT) arrive pre-computed from the first pipeline stage, so
// this block is only a mode-driven select plus one signed compare.
// zero_o / clip_o flag lanes forced to 0 or saturated to the clip value.
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W
) (
    input  logic signed [DATA_W-1:0] x_i,
    input  act_mode_t                mode_i,
    input  logic signed [DATA_W-1:0] clip_i,
    input  logic                     sign_i,
    input  logic signed [DATA_W-1:0] leak_i,
    output logic signed [DATA_W-1:0] y_o,
    output logic                     zero_o,
    output logic                     clip_o
);

    logic nonpos;
    assign nonpos = sign_i || (x_i == '0);

    // Mode select; a negative clip ceiling collapses every lane to 0.
    always_comb begin
        y_o    = x_i;
        zero_o = 1'b0;
        clip_o = 1'b0;
        case (mode_i)
            ACT_RELU: begin
                if (nonpos) begin
                    y_o    = '0;
                    zero_o = 1'b1;
                end
            end
            ACT_LEAKY: begin
                if (sign_i) begin
                    y_o = leak_i;
                end
            end
            ACT_CLIP: begin
                if (nonpos || clip_i[DATA_W-1]) begin
                    y_o    = '0;
                    zero_o = 1'b1;
                end else if (x_i > clip_i) begin
                    y_o    = clip_i;
                    clip_o = 1'b1;
                end
            end
            default: begin
                y_o = x_i;
            end
        endcase
    end

endmodule

// File: rtl/activation_unit_mp.sv
// Multi-lane, multi-mode activation stage (bypass / ReLU / leaky / clipped).
// Two register stages with a shared advance enable; LANES act_lane instances
// evaluate the second stage. Define ACT_STATS_EN to add zero/clip lane
// counters (stat_zero_cnt, stat_clip_cnt) with a synchronous clear (stat_clr).
//
// Handshake: a beat moves on a rising edge where valid && ready. in_ready is
// the advance enable (!out_valid || out_ready); when out_valid is high and
// out_ready low both stages freeze and out_data is held unchanged.
module activation_unit_mp
    import act_pkg::*;
#(
    parameter int DATA_W     = ACT_DATA_W,
    parameter int LANES      = ACT_LANES,
    parameter int LEAK_SHIFT = ACT_LEAK_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [1:0]              in_mode,
    input  logic [DATA_W-1:0]       in_clip,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef ACT_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [31:0]             stat_zero_cnt,
    output logic [31:0]             stat_clip_cnt
`endif
);

    logic                    adv;
    logic [LANES-1:0]        sign_d;
    logic [LANES*DATA_W-1:0] leak_d;
    logic [LANES*DATA_W-1:0] res_d;
    logic [LANES-1:0]        zero_flag;
    logic [LANES-1:0]        clip_flag;

    logic [LANES*DATA_W-1:0] s1_data_q;
    act_mode_t               s1_mode_q;
    logic [DATA_W-1:0]       s1_clip_q;
    logic [LANES-1:0]        s1_sign_q;
    logic [LANES*DATA_W-1:0] s1_leak_q;
    logic                    s1_valid_q;
    logic [LANES*DATA_W-1:0] out_data_q;
    logic                    out_valid_q;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign sign_d[i] = in_data[i*DATA_W + DATA_W-1];
        assign leak_d[i*DATA_W +: DATA_W] = $signed(in_data[i*DATA_W +: DATA_W]) >>> LEAK_SHIFT;

        act_lane #(.DATA_W(DATA_W)) u_lane (
            .x_i    (s1_data_q[i*DATA_W +: DATA_W]),
            .mode_i (s1_mode_q),
            .clip_i (s1_clip_q),
            .sign_i (s1_sign_q[i]),
            .leak_i (s1_leak_q[i*DATA_W +: DATA_W]),
            .y_o    (res_d[i*DATA_W +: DATA_W]),
            .zero_o (zero_flag[i]),
            .clip_o (clip_flag[i])
        );
    end

    // Stage 1: capture the beat, its mode/clip and the per-lane pre-terms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q  <= '0;
            s1_mode_q  <= ACT_BYPASS;
            s1_clip_q  <= '0;
            s1_sign_q  <= '0;
            s1_leak_q  <= '0;
            s1_valid_q <= 1'b0;
        end else if (adv) begin
            s1_data_q  <= in_data;
            s1_mode_q  <= in_mode;
            s1_clip_q  <= in_clip;
            s1_sign_q  <= sign_d;
            s1_leak_q  <= leak_d;
            s1_valid_q <= in_valid;
        end
    end

    // Stage 2: register the activated lanes; bubbles travel as out_valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            out_data_q  <= res_d;
            out_valid_q <= s1_valid_q;
        end
    end

`ifdef ACT_STATS_EN
    logic [32:0] zero_inc;
    logic [32:0] clip_inc;
    logic [32:0] zero_sum;
    logic [32:0] clip_sum;
    logic [31:0] zero_cnt_q;
    logic [31:0] clip_cnt_q;

    // Per-beat lane counts and saturating next values for both counters.
    always_comb begin
        zero_inc = '0;
        clip_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            zero_inc = zero_inc + 33'(zero_flag[i]);
            clip_inc = clip_inc + 33'(clip_flag[i]);
        end
        zero_sum = {1'b0, zero_cnt_q} + zero_inc;
        clip_sum = {1'b0, clip_cnt_q} + clip_inc;
        if (zero_sum[32]) zero_sum = {1'b0, 32'hFFFF_FFFF};
        if (clip_sum[32]) clip_sum = {1'b0, 32'hFFFF_FFFF};
    end

    // Counters advance with each beat leaving stage 2; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt_q <= '0;
            clip_cnt_q <= '0;
        end else if (stat_clr) begin
            zero_cnt_q <= '0;
            clip_cnt_q <= '0;
        end else if (adv && s1_valid_q) begin
            zero_cnt_q <= zero_sum[31:0];
            clip_cnt_q <= clip_sum[31:0];
        end
    end

    assign stat_zero_cnt = zero_cnt_q;
    assign stat_clip_cnt = clip_cnt_q;
`else
    logic unused_flags;
    assign unused_flags = ^{zero_flag, clip_flag};
`endif

endmodule

// File: doc/activation_unit_mp.md
Name: activation_unit_mp

Overview:
- Multi-lane, multi-mode activation stage for the inference datapath; successor to the single-lane ReLU stage.
- Applies one of bypass / ReLU / leaky ReLU / clipped ReLU to LANES signed fixed-point elements per beat.
- 2-stage valid/ready pipeline; sits between the MAC accumulator output and the next-layer buffer.

Parameters:
- DATA_W, 32, element width (signed two's complement fixed-point).
- LANES, 4, elements per beat.
- LEAK_SHIFT, 3, leaky slope = 2^-LEAK_SHIFT (arithmetic right shift); legal range 1..DATA_W-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  LANES*DATA_W  packed elements; lane i at [i*DATA_W +: DATA_W]
- in_mode  in  2  0=bypass, 1=ReLU, 2=leaky ReLU, 3=clipped ReLU; captured per beat with in_data
- in_clip  in  DATA_W  clip ceiling for mode 3 (signed, must be >= 0); captured per beat
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat this cycle
- out_data  out  LANES*DATA_W  activated elements, same packing
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts

Behaviour:
- Reset values: out_data=0, out_valid=0, stage-1 valid=0, all pipeline registers 0. in_ready is 1 while in reset and immediately after release.
- Advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - Input transfer when in_valid && in_ready.
- Stage 1 (on adv):
  - Register in_data, in_mode and in_clip.
  - Register per-lane sign bit and the leaky term x>>>LEAK_SHIFT.
  - s1_valid <= in_valid.
- Stage 2 (on adv):
  - Compute the result below per lane; out_data <= result; out_valid <= s1_valid.
  - Bypass: y=x.
  - ReLU: y = x if x>0, else 0. x=0 gives 0; the most negative value gives 0.
  - Leaky: y = x if x>=0, else x>>>LEAK_SHIFT (floor rounding). Example: -1 gives -1; -8 with shift 3 gives -1.
  - Clipped: y = 0 if x<=0; clip if x>clip; x otherwise. If clip<0, result is 0.
- Latency: exactly 2 cycles from input transfer to out_valid, with no stall.
- Throughput: 1 beat/cycle.
- Backpressure:
  - out_valid && !out_ready freezes both stages; out_data is held stable, and in_ready=0 in the same cycle.
  - Bubbles are not squeezed out during a stall.
- Lanes are independent; the mode and clip value apply to all lanes of a beat.
- A mode change between consecutive beats takes effect exactly at the beat boundary; there are no stale-mode beats.
- No output beat is lost or duplicated across any ready/valid pattern. Data order is preserved.
- rst_n asserted mid-stream: all in-flight beats are discarded and out_valid drops asynchronously.
- X on in_data while in_valid=0 must not propagate into out_valid.

Optional Feature:
- Macro: ACT_STATS_EN.
- When defined, adds the following outputs:
  - stat_zero_cnt (out, 32): count of lanes forced to 0 by ReLU or clipped mode.
  - stat_clip_cnt (out, 32): count of lanes saturated to clip.
  - stat_clr (in, 1): synchronous clear of both counters.
- Counters update on the stage-2 advance with s1_valid, adding 0..LANES per beat.
- Counters saturate at 2^32-1. They reset to 0 on rst_n.
- stat_clr wins over a simultaneous increment.
- When not defined: these ports and counters do not exist; datapath behaviour and latency are identical.

Decomposition:
- Package act_pkg holds:
  - Mode localparams ACT_BYPASS=2'd0, ACT_RELU=2'd1, ACT_LEAKY=2'd2, ACT_CLIP=2'd3.
  - Typedef act_mode_t (2-bit).
  - Default DATA_W/LANES constants.
- One sub-module, act_lane: the combinational per-lane function (x, mode, clip, sign, leaky term) giving y, plus zero/clip flags for stats. The top generates LANES instances of act_lane and owns the pipeline and handshake.

Test Plan:
- ReLU, LANES=4, in_data={-5, 0, 7, 0x80000000}, out_ready=1 -> exactly 2 cycles later out_data={0, 0, 7, 0}, out_valid high for 1 cycle.
- Leaky, LEAK_SHIFT=3, in_data={-8, -1, -17, 100} -> out_data={-1, -1, -3, 100}.
- Clipped, in_clip=6.0 (0x00060000 in Q16.16), in_data={0x00010000, 0x00070000, -0x00010000, 0x00060000} -> out_data={0x00010000, 0x00060000, 0, 0x00060000}.
- Stream 8 beats alternating modes 1/2 with random out_ready (~50%) -> scoreboard matches the reference model in order; out_data stable while stalled; in_ready==out_ready whenever out_valid=1.
- Assert rst_n low with 2 beats in flight -> out_valid=0 immediately, no beats emitted after release, in_ready=1.
- ACT_STATS_EN: 3 clipped beats with 2 zero lanes and 1 clip lane each -> stat_zero_cnt=6, stat_clip_cnt=3; pulse stat_clr together with a 4th beat -> both counters read 0.
